// File: rtl/tea_pkg.sv
// Shared types, constants and the TEA mixing function for the TEA block engine.
package tea_pkg;

    typedef logic [31:0]  tea_word_t;
    typedef logic [63:0]  tea_block_t;
    typedef logic [127:0] tea_key_t;

    localparam tea_word_t TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF_A = 2'd1,
        HALF_B = 2'd2,
        DONE   = 2'd3
    } tea_state_e;

    // TEA mixing function; all arithmetic wraps mod 2^32, right shift is logical.
    function automatic tea_word_t tea_f(
        input tea_word_t x,
        input tea_word_t kl,
        input tea_word_t kr,
        input tea_word_t s
    );
        return ((x << 4) + kl) ^ (x + s) ^ ((x >> 5) + kr);
    endfunction

endpackage

// File: rtl/tea_half_round_unit.sv
// One TEA half-round: target +/- F(source, key pair, sum). Purely combinational.
module tea_half_round_unit
    import tea_pkg::*;
(
    input  logic [31:0] i_target,
    input  logic [31:0] i_source,
    input  logic [31:0] i_key_l,
    input  logic [31:0] i_key_r,
    input  logic [31:0] i_sum,
    input  logic        i_sub,
    output logic [31:0] o_word
);

    logic [31:0] w_f;

    assign w_f    = tea_f(i_source, i_key_l, i_key_r, i_sum);
    assign o_word = i_sub ? (i_target - w_f) : (i_target + w_f);

endmodule

// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryption engine: one half-round per clock through a
// single shared half-round unit, valid/ready on both sides.
// Optional encryption mode is enabled by defining TEA_DECRYPT_CORE_ENC_EN,
// which adds the mode_enc input (sampled when a block is accepted).
module tea_decrypt_core
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
`ifdef TEA_DECRYPT_CORE_ENC_EN
    input  logic         mode_enc,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
        $error("tea_decrypt_core: ROUNDS must be in 1..64");
    end

    localparam int              CNT_W        = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_RND    = CNT_W'(ROUNDS - 1);
    // Decryption walks the key schedule backwards from ROUNDS*DELTA.
    localparam logic [31:0]     DEC_SUM_INIT = 32'(ROUNDS) * DELTA;

    tea_state_e       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [63:0]      r_out_data;
    tea_word_t        r_v0;
    tea_word_t        r_v1;
    tea_word_t        r_sum;
    tea_key_t         r_key;
    logic [CNT_W-1:0] r_rnd;
    logic             r_enc;

    logic             w_mode_enc;
    logic             w_accept;
    logic             w_tgt_hi;
    tea_word_t        w_target;
    tea_word_t        w_source;
    tea_word_t        w_key_l;
    tea_word_t        w_key_r;
    tea_word_t        w_sum_use;
    tea_word_t        w_new;

`ifdef TEA_DECRYPT_CORE_ENC_EN
    assign w_mode_enc = mode_enc;
`else
    assign w_mode_enc = 1'b0;
`endif

    assign w_accept = in_valid && r_in_ready;

    // Decrypt updates v1 in HALF_A and v0 in HALF_B; encrypt does the reverse.
    // The updated word always pairs with k2/k3 when it is v1, k0/k1 when it is v0.
    assign w_tgt_hi = (r_state == HALF_A) ^ r_enc;
    assign w_target = w_tgt_hi ? r_v1 : r_v0;
    assign w_source = w_tgt_hi ? r_v0 : r_v1;
    assign w_key_l  = w_tgt_hi ? r_key[95:64]  : r_key[31:0];
    assign w_key_r  = w_tgt_hi ? r_key[127:96] : r_key[63:32];
    // Encryption advances the sum at the start of each round, before HALF_A uses it.
    assign w_sum_use = (r_enc && (r_state == HALF_A)) ? (r_sum + DELTA) : r_sum;

    tea_half_round_unit u_half_round (
        .i_target (w_target),
        .i_source (w_source),
        .i_key_l  (w_key_l),
        .i_key_r  (w_key_r),
        .i_sum    (w_sum_use),
        .i_sub    (!r_enc),
        .o_word   (w_new)
    );

    // Control FSM and datapath registers; all handshake outputs are registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_v0        <= '0;
            r_v1        <= '0;
            r_sum       <= '0;
            r_key       <= '0;
            r_rnd       <= '0;
            r_enc       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_v0       <= in_data[31:0];
                        r_v1       <= in_data[63:32];
                        r_key      <= in_key;
                        r_enc      <= w_mode_enc;
                        r_sum      <= w_mode_enc ? 32'd0 : DEC_SUM_INIT;
                        r_rnd      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= HALF_A;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                HALF_A: begin
                    if (w_tgt_hi) r_v1 <= w_new;
                    else          r_v0 <= w_new;
                    if (r_enc) r_sum <= w_sum_use;
                    r_state <= HALF_B;
                end
                HALF_B: begin
                    if (w_tgt_hi) r_v1 <= w_new;
                    else          r_v0 <= w_new;
                    if (!r_enc) r_sum <= r_sum - DELTA;
                    r_rnd <= r_rnd + CNT_W'(1);
                    if (r_rnd == LAST_RND) begin
                        r_out_data  <= w_tgt_hi ? {w_new, r_v0} : {r_v1, w_new};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= HALF_A;
                    end
                end
                DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Self-checking bench for tea_decrypt_core: four instances with different
// round counts, checked against a plain TEA software model.
`timescale 1ns/1ps
module tb_tea_decrypt_core;

    localparam int          N_DUT = 4;
    localparam int          R_LIST [N_DUT] = '{32, 1, 16, 64};
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_in_valid  [N_DUT];
    logic         s_in_ready  [N_DUT];
    logic [63:0]  s_in_data   [N_DUT];
    logic [127:0] s_in_key    [N_DUT];
`ifdef TEA_DECRYPT_CORE_ENC_EN
    logic         s_mode_enc  [N_DUT];
`endif
    logic         s_out_valid [N_DUT];
    logic         s_out_ready [N_DUT];
    logic [63:0]  s_out_data  [N_DUT];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        tea_decrypt_core #(.ROUNDS(R_LIST[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_in_valid[g]),
            .in_ready  (s_in_ready[g]),
            .in_data   (s_in_data[g]),
            .in_key    (s_in_key[g]),
`ifdef TEA_DECRYPT_CORE_ENC_EN
            .mode_enc  (s_mode_enc[g]),
`endif
            .out_valid (s_out_valid[g]),
            .out_ready (s_out_ready[g]),
            .out_data  (s_out_data[g])
        );
    end

    // Reference TEA, written as the textbook loop over full rounds.
    function automatic logic [63:0] ref_tea(input logic [63:0] blk, input logic [127:0] key,
                                            input int rounds, input bit enc);
        logic [31:0] v0, v1, sum;
        logic [31:0] k [4];
        v0 = blk[31:0];
        v1 = blk[63:32];
        for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
        if (enc) begin
            sum = 32'd0;
            for (int i = 0; i < rounds; i++) begin
                sum = sum + DELTA;
                v0 = v0 + (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                v1 = v1 + (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
            end
        end else begin
            sum = 32'(rounds) * DELTA;
            for (int i = 0; i < rounds; i++) begin
                v1 = v1 - (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
                v0 = v0 - (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                sum = sum - DELTA;
            end
        end
        return {v1, v0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) at negedges until the given instance is ready.
    task automatic wait_ready(input int idx);
        int n = 0;
        while (!s_in_ready[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(s_in_ready[idx]), 64'd1);
    endtask

    // Presents one block, returns at the negedge right after the accept edge.
    task automatic send(input int idx, input logic [63:0] data, input logic [127:0] key,
                        input bit enc, input bit keep_valid, output logic [63:0] exp);
        exp = ref_tea(data, key, R_LIST[idx], enc);
        wait_ready(idx);
        s_in_valid[idx] = 1'b1;
        s_in_data[idx]  = data;
        s_in_key[idx]   = key;
`ifdef TEA_DECRYPT_CORE_ENC_EN
        s_mode_enc[idx] = enc;
`endif
        @(posedge clk);
        @(negedge clk);
        check("accept_in_ready_low", 64'(s_in_ready[idx]), 64'd0);
        if (!keep_valid) s_in_valid[idx] = 1'b0;
    endtask

    // Called at the negedge after the accept edge; checks latency and data.
    task automatic collect(input int idx, input logic [63:0] exp, input string tag);
        int k = 0;
        while (!s_out_valid[idx] && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(2 * R_LIST[idx]));
        check({tag, "_data"}, s_out_data[idx], exp);
    endtask

    task automatic handshake(input int idx);
        s_out_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_out_ready[idx] = 1'b0;
        check("hs_out_valid_low", 64'(s_out_valid[idx]), 64'd0);
        check("hs_in_ready_high", 64'(s_in_ready[idx]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  exp_a, exp_b, data_a, data_b, hold_data;
        logic [127:0] key_a, key_b;
        bit           enc;

        for (int i = 0; i < N_DUT; i++) begin
            s_in_valid[i]  = 1'b0;
            s_in_data[i]   = '0;
            s_in_key[i]    = '0;
            s_out_ready[i] = 1'b0;
`ifdef TEA_DECRYPT_CORE_ENC_EN
            s_mode_enc[i]  = 1'b0;
`endif
        end

        // Reset state
        #23;
        for (int i = 0; i < N_DUT; i++) begin
            check("rst_in_ready", 64'(s_in_ready[i]), 64'd0);
            check("rst_out_valid", 64'(s_out_valid[i]), 64'd0);
            check("rst_out_data", s_out_data[i], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("release_in_ready_low", 64'(s_in_ready[0]), 64'd0);
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++)
            check("release_in_ready_high", 64'(s_in_ready[i]), 64'd1);

        // Known vector: encrypted zero block under zero key decrypts to zero
        send(0, {32'h94BAA940, 32'h41EA3A0A}, 128'd0, 1'b0, 1'b0, exp_a);
        collect(0, 64'h0, "known_vector");
        handshake(0);

        // Backpressure: hold output 10 cycles with a competing in_valid
        data_a = {$urandom(), $urandom()};
        key_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data_a, key_a, 1'b0, 1'b0, exp_a);
        collect(0, exp_a, "bp_block");
        s_in_valid[0] = 1'b1;
        s_in_data[0]  = {$urandom(), $urandom()};
        hold_data = s_out_data[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out_data_stable", s_out_data[0], exp_a);
            check("bp_out_valid_held", 64'(s_out_valid[0]), 64'd1);
            check("bp_in_ready_low", 64'(s_in_ready[0]), 64'd0);
        end
        check("bp_out_data_initial", hold_data, exp_a);
        s_in_valid[0] = 1'b0;
        handshake(0);

        // Back-to-back with garbage on the inputs while busy
        data_a = {$urandom(), $urandom()};
        key_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_b = {$urandom(), $urandom()};
        key_b  = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data_a, key_a, 1'b0, 1'b1, exp_a);
        s_in_data[0] = {$urandom(), $urandom()};
        s_in_key[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        collect(0, exp_a, "b2b_first");
        exp_b = ref_tea(data_b, key_b, R_LIST[0], 1'b0);
        s_in_data[0] = data_b;
        s_in_key[0]  = key_b;
        handshake(0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_accepted", 64'(s_in_ready[0]), 64'd0);
        s_in_valid[0] = 1'b0;
        s_in_data[0]  = {$urandom(), $urandom()};
        collect(0, exp_b, "b2b_second");
        handshake(0);

        // Reset mid-run aborts the block
        send(0, {$urandom(), $urandom()}, 128'd5, 1'b0, 1'b0, exp_a);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(s_out_valid[0]), 64'd0);
        check("midrst_in_ready", 64'(s_in_ready[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready", 64'(s_in_ready[0]), 64'd1);
        check("midrst_no_output", 64'(s_out_valid[0]), 64'd0);
        data_a = {$urandom(), $urandom()};
        key_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data_a, key_a, 1'b0, 1'b0, exp_a);
        collect(0, exp_a, "post_reset");
        // Reset while a result is waiting drops out_valid immediately
        rst_n = 1'b0;
        #1;
        check("donerst_out_valid", 64'(s_out_valid[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("donerst_in_ready", 64'(s_in_ready[0]), 64'd1);

`ifdef TEA_DECRYPT_CORE_ENC_EN
        // Encrypt zero under zero key, then decrypt the result back
        send(0, 64'd0, 128'd0, 1'b1, 1'b0, exp_a);
        collect(0, {32'h94BAA940, 32'h41EA3A0A}, "enc_known");
        hold_data = s_out_data[0];
        handshake(0);
        send(0, hold_data, 128'd0, 1'b0, 1'b0, exp_a);
        collect(0, 64'd0, "enc_roundtrip");
        handshake(0);
`endif

        // Round-count sweep with random data/keys (and modes when available)
        for (int d = 0; d < N_DUT; d++) begin
            for (int t = 0; t < 3; t++) begin
                data_a = {$urandom(), $urandom()};
                key_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef TEA_DECRYPT_CORE_ENC_EN
                enc = bit'($urandom_range(0, 1));
`else
                enc = 1'b0;
`endif
                send(d, data_a, key_a, enc, 1'b0, exp_a);
                collect(d, exp_a, "sweep");
                handshake(d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
